nf_uart_fifo: RTL

Buffered, parametrised UART peripheral for the nanoFOX bus. It replaces the single-byte, handshake-per-byte UART with TX/RX FIFOs, a configurable frame format (optional even/odd parity, 1 or 2 stop bits), a status register with sticky error flags, and mid-bit RX sampling. It sits on the same simple word bus (addr/we/wd/rd) as the other nanoFOX slaves.

---
 rtl/nf_uart_pkg.sv | 46 ++++
 rtl/nf_uart_fifo_sync.sv | 54 +++++
 rtl/nf_uart_fifo.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nf_uart_pkg.sv
// Shared definitions for the buffered nanoFOX UART: register offsets, bit
// positions, FSM state encodings and the parity helper.
package nf_uart_pkg;

   // Word offsets as seen on addr[4:2].
   localparam logic [2:0] REG_CR = 3'd0;
   localparam logic [2:0] REG_TX = 3'd1;
   localparam logic [2:0] REG_RX = 3'd2;
   localparam logic [2:0] REG_DR = 3'd3;
   localparam logic [2:0] REG_SR = 3'd4;

   localparam int CR_TR_EN   = 0;
   localparam int CR_REC_EN  = 1;
   localparam int CR_PAR_EN  = 2;
   localparam int CR_PAR_ODD = 3;
   localparam int CR_STOP2   = 4;
   localparam int CR_TX_CLR  = 5;
   localparam int CR_RX_CLR  = 6;

   localparam int SR_TX_FULL   = 0;
   localparam int SR_TX_EMPTY  = 1;
   localparam int SR_RX_FULL   = 2;
   localparam int SR_RX_EMPTY  = 3;
   localparam int SR_RX_OVF    = 4;
   localparam int SR_PAR_ERR   = 5;
   localparam int SR_FRAME_ERR = 6;
   localparam int SR_TX_BUSY   = 7;
   localparam int SR_TX_OVF    = 8;
   localparam int SR_RX_COUNT  = 16;
   localparam int SR_TX_COUNT  = 24;

   localparam logic [15:0] DR_MIN = 16'd2;

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
   } rx_state_t;

   function automatic logic parity_bit(input logic [7:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

endpackage

// File: rtl/nf_uart_fifo_sync.sv
// Synchronous FIFO with clear. A push while full is accepted only when a
// pop happens in the same cycle; a pop while empty is ignored.
module nf_uart_fifo_sync #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign data    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!resetn || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (!do_push && do_pop)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (resetn && !clr && do_push)
         mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/nf_uart_fifo.sv
// Buffered UART slave for the nanoFOX word bus: TX/RX FIFOs, optional
// parity, 1/2 stop bits, sticky W1C error flags, mid-bit RX sampling.
module nf_uart_fifo
   import nf_uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int DR_RST     = 434
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        uart_tx,
   input  logic        uart_rx
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [2:0]  reg_sel;
   logic        wr_cr, wr_tx, wr_rx, wr_dr, wr_sr;
   logic        tr_en, rec_en, par_en, par_odd, stop2;
   logic [15:0] dr;
   logic        tx_ovf, rx_ovf, par_err, frame_err;
   logic        tx_clr, rx_clr;

   logic [7:0]    tx_head, rx_head;
   logic [CW-1:0] tx_count, rx_count;
   logic          tx_full, tx_empty, rx_full, rx_empty;

   logic unused_bits;
   assign unused_bits = ^{addr[31:5], addr[1:0], wd[31:16]};

   assign reg_sel = addr[4:2];
   assign wr_cr   = we && (reg_sel == REG_CR);
   assign wr_tx   = we && (reg_sel == REG_TX);
   assign wr_rx   = we && (reg_sel == REG_RX);
   assign wr_dr   = we && (reg_sel == REG_DR);
   assign wr_sr   = we && (reg_sel == REG_SR);
   assign tx_clr  = wr_cr && wd[CR_TX_CLR];
   assign rx_clr  = wr_cr && wd[CR_RX_CLR];

   // ---------------- TX engine ----------------
   tx_state_t   tx_state, tx_next;
   logic [15:0] tx_cnt, tx_dr;
   logic [2:0]  tx_bit;
   logic [7:0]  tx_shift;
   logic        tx_par, tx_par_en, tx_stop2, tx_stop_second;
   logic        tx_tick, tx_last_stop, tx_start, tx_busy;

   assign tx_tick      = (tx_cnt == tx_dr - 16'd1);
   assign tx_last_stop = (tx_state == TX_STOP) && tx_tick && (!tx_stop2 || tx_stop_second);
   // A new frame may start straight out of the last stop bit, so back-to-back bytes have no gap.
   assign tx_start     = tr_en && !tx_empty && !tx_clr &&
                         ((tx_state == TX_IDLE) || tx_last_stop);

   always_ff @(posedge clk) begin
      if (!resetn) tx_state <= TX_IDLE;
      else         tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE:   if (tx_start) tx_next = TX_START;
         TX_START:  if (tx_tick) tx_next = TX_DATA;
         TX_DATA:   if (tx_tick && tx_bit == 3'd7) tx_next = tx_par_en ? TX_PARITY : TX_STOP;
         TX_PARITY: if (tx_tick) tx_next = TX_STOP;
         TX_STOP:   if (tx_last_stop) tx_next = tx_start ? TX_START : TX_IDLE;
         default:   tx_next = TX_IDLE;
      endcase
   end

   always_comb begin
      uart_tx = 1'b1;
      tx_busy = 1'b1;
      case (tx_state)
         TX_IDLE:   tx_busy = 1'b0;
         TX_START:  uart_tx = 1'b0;
         TX_DATA:   uart_tx = tx_shift[0];
         TX_PARITY: uart_tx = tx_par;
         default:   uart_tx = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         tx_cnt         <= '0;
         tx_dr          <= 16'(DR_RST);
         tx_bit         <= '0;
         tx_shift       <= '0;
         tx_par         <= 1'b0;
         tx_par_en      <= 1'b0;
         tx_stop2       <= 1'b0;
         tx_stop_second <= 1'b0;
      end else if (tx_start) begin
         tx_cnt         <= '0;
         tx_dr          <= dr;
         tx_bit         <= '0;
         tx_shift       <= tx_head;
         tx_par         <= parity_bit(tx_head, par_odd);
         tx_par_en      <= par_en;
         tx_stop2       <= stop2;
         tx_stop_second <= 1'b0;
      end else if (tx_state != TX_IDLE) begin
         if (tx_tick) begin
            tx_cnt <= '0;
            if (tx_state == TX_DATA) begin
               tx_shift <= {1'b0, tx_shift[7:1]};
               tx_bit   <= tx_bit + 1'b1;
            end
            if (tx_state == TX_STOP) tx_stop_second <= 1'b1;
         end else begin
            tx_cnt <= tx_cnt + 16'd1;
         end
      end
   end

   // ---------------- RX engine ----------------
   rx_state_t   rx_state, rx_next;
   logic        rx_s1, rx_s2, rx_prev, rx_fall;
   logic [15:0] rx_cnt, rx_dr;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shift;
   logic        rx_par_en, rx_par_odd, rx_par_bad;
   logic        rx_half_tick, rx_tick, rx_stop_sample, rx_good;
   logic        frame_err_set, par_err_set, rx_ovf_set, tx_ovf_set;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= uart_rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   assign rx_fall        = rx_prev && !rx_s2;
   assign rx_half_tick   = (rx_cnt == (rx_dr >> 1) - 16'd1);
   assign rx_tick        = (rx_cnt == rx_dr - 16'd1);
   assign rx_stop_sample = rec_en && (rx_state == RX_STOP) && rx_tick;
   assign frame_err_set  = rx_stop_sample && !rx_s2;
   assign par_err_set    = rx_stop_sample && rx_par_bad;

   always_ff @(posedge clk) begin
      if (!resetn) rx_state <= RX_IDLE;
      else         rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      if (!rec_en) begin
         rx_next = RX_IDLE;
      end else begin
         case (rx_state)
            RX_IDLE:   if (rx_fall) rx_next = RX_START;
            RX_START:  if (rx_half_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_tick && rx_bit == 3'd7) rx_next = rx_par_en ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_tick) rx_next = RX_STOP;
            RX_STOP:   if (rx_tick) rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rx_cnt     <= '0;
         rx_dr      <= 16'(DR_RST);
         rx_bit     <= '0;
         rx_shift   <= '0;
         rx_par_en  <= 1'b0;
         rx_par_odd <= 1'b0;
         rx_par_bad <= 1'b0;
         rx_good    <= 1'b0;
      end else begin
         // The byte is pushed one clock after the stop sample.
         rx_good <= rx_stop_sample && rx_s2 && !rx_par_bad;
         case (rx_state)
            RX_IDLE: begin
               rx_cnt     <= '0;
               rx_bit     <= '0;
               rx_par_bad <= 1'b0;
               rx_dr      <= dr;
               rx_par_en  <= par_en;
               rx_par_odd <= par_odd;
            end
            RX_START: rx_cnt <= rx_half_tick ? 16'd0 : rx_cnt + 16'd1;
            default: begin
               if (rx_tick) begin
                  rx_cnt <= '0;
                  if (rx_state == RX_DATA) begin
                     rx_shift <= {rx_s2, rx_shift[7:1]};
                     rx_bit   <= rx_bit + 1'b1;
                  end
                  if (rx_state == RX_PARITY)
                     rx_par_bad <= (rx_s2 != parity_bit(rx_shift, rx_par_odd));
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
         endcase
      end
   end

   // ---------------- FIFOs ----------------
   nf_uart_fifo_sync #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
      .clk(clk), .resetn(resetn), .clr(tx_clr),
      .push(wr_tx), .pop(tx_start), .wdata(wd[7:0]), .data(tx_head),
      .count(tx_count), .full(tx_full), .empty(tx_empty)
   );

   nf_uart_fifo_sync #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
      .clk(clk), .resetn(resetn), .clr(rx_clr),
      .push(rx_good), .pop(wr_rx), .wdata(rx_shift), .data(rx_head),
      .count(rx_count), .full(rx_full), .empty(rx_empty)
   );

   assign tx_ovf_set = wr_tx && tx_full && !tx_start && !tx_clr;
   assign rx_ovf_set = rx_good && rx_full && !wr_rx && !rx_clr;

   // ---------------- Registers ----------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         tr_en     <= 1'b0;
         rec_en    <= 1'b0;
         par_en    <= 1'b0;
         par_odd   <= 1'b0;
         stop2     <= 1'b0;
         dr        <= 16'(DR_RST);
         tx_ovf    <= 1'b0;
         rx_ovf    <= 1'b0;
         par_err   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (wr_cr) begin
            tr_en   <= wd[CR_TR_EN];
            rec_en  <= wd[CR_REC_EN];
            par_en  <= wd[CR_PAR_EN];
            par_odd <= wd[CR_PAR_ODD];
            stop2   <= wd[CR_STOP2];
         end
         if (wr_dr) dr <= (wd[15:0] < DR_MIN) ? DR_MIN : wd[15:0];
         // A new event in the same cycle as a W1C wins over the clear.
         tx_ovf    <= (tx_ovf    && !(wr_sr && wd[SR_TX_OVF]))    || tx_ovf_set;
         rx_ovf    <= (rx_ovf    && !(wr_sr && wd[SR_RX_OVF]))    || rx_ovf_set;
         par_err   <= (par_err   && !(wr_sr && wd[SR_PAR_ERR]))   || par_err_set;
         frame_err <= (frame_err && !(wr_sr && wd[SR_FRAME_ERR])) || frame_err_set;
      end
   end

   always_comb begin
      rd = '0;
      case (reg_sel)
         REG_CR: begin
            rd[CR_TR_EN]   = tr_en;
            rd[CR_REC_EN]  = rec_en;
            rd[CR_PAR_EN]  = par_en;
            rd[CR_PAR_ODD] = par_odd;
            rd[CR_STOP2]   = stop2;
         end
         REG_RX: rd[7:0]  = rx_empty ? 8'h00 : rx_head;
         REG_DR: rd[15:0] = dr;
         REG_SR: begin
            rd[SR_TX_FULL]          = tx_full;
            rd[SR_TX_EMPTY]         = tx_empty;
            rd[SR_RX_FULL]          = rx_full;
            rd[SR_RX_EMPTY]         = rx_empty;
            rd[SR_RX_OVF]           = rx_ovf;
            rd[SR_PAR_ERR]          = par_err;
            rd[SR_FRAME_ERR]        = frame_err;
            rd[SR_TX_BUSY]          = tx_busy;
            rd[SR_TX_OVF]           = tx_ovf;
            rd[SR_RX_COUNT +: 8]    = 8'(rx_count);
            rd[SR_TX_COUNT +: 8]    = 8'(tx_count);
         end
         default: rd = '0;
      endcase
   end

endmodule
